// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared FSM state encodings and echo-mode constants for the
//                UART loopback echo buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Echo engine states: wait for work, strobe TX, wait for UART to go busy
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // MODE parameter values
    localparam int MODE_ECHO  = 0;
    localparam int MODE_UPPER = 1;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/echo_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : echo_fifo
//  Description : Synchronous FIFO, DATA_W x DEPTH, first-word-fall-through
//                head output. Push while full is accepted only together
//                with a pop; pop while empty is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] C_FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full  = (count_q == C_FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Qualify requests and advance pointers/occupancy; pointers wrap modulo DEPTH
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : echo_fifo
`default_nettype wire

// File: rtl/uart_echo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_echo_buffer
//  Description : Buffered UART loopback. Received words are queued in a FIFO
//                and re-issued to the UART transmitter one frame at a time,
//                with overrun tracking and optional upper-case folding.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_echo_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int MODE   = 0,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DATA_W-1:0]        rx_data,
    input  logic                     rx_enable,
    input  logic                     tx_ready,
    input  logic                     loop_en,
    input  logic                     clear_overrun,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_enable,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    output logic [CNT_W-1:0]         drop_cnt
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_enable_q, tx_enable_d;
    logic              overrun_q, overrun_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [DATA_W-1:0] head_folded;
    logic              drop;

    echo_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rx_enable),
        .push_data (rx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Optional case folding applied to the word as it leaves the FIFO
    if (MODE == MODE_UPPER) begin : g_fold_upper
        assign head_folded = (fifo_head >= DATA_W'(8'h61) && fifo_head <= DATA_W'(8'h7A))
                           ? fifo_head - DATA_W'(8'h20) : fifo_head;
    end else begin : g_fold_none
        assign head_folded = fifo_head;
    end

    // A word is lost only when full and no pop frees a slot in the same cycle
    assign drop = rx_enable && fifo_full && !fifo_pop;

    // Echo FSM: pop and load in IDLE, strobe in SEND, wait for UART busy in DRAIN
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_enable_d = 1'b0;
        fifo_pop    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && tx_ready && loop_en) begin
                    fifo_pop    = 1'b1;
                    tx_data_d   = head_folded;
                    tx_enable_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overrun and saturating drop counter; a coincident drop beats clear
    always_comb begin
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;
        if (clear_overrun) begin
            overrun_d  = drop;
            drop_cnt_d = drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overrun_d = 1'b1;
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= '0;
            tx_enable_q <= 1'b0;
            overrun_q   <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_enable_q <= tx_enable_d;
            overrun_q   <= overrun_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_enable = tx_enable_q;
    assign overrun   = overrun_q;
    assign drop_cnt  = drop_cnt_q;

endmodule : uart_echo_buffer
`default_nettype wire

// File: tb/tb_uart_echo_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_echo_buffer
//  Description : Directed self-checking bench for uart_echo_buffer. One
//                instance folds case (MODE=1), a second plain-echo instance
//                shares every input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_echo_buffer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_enable = 1'b0;
    logic       tx_ready = 1'b0;
    logic       loop_en = 1'b0;
    logic       clear_overrun = 1'b0;

    logic [7:0] tx_data_u, tx_data_e;
    logic       tx_enable_u, tx_enable_e;
    logic [4:0] fifo_count_u, fifo_count_e;
    logic       overrun_u, overrun_e;
    logic [7:0] drop_cnt_u, drop_cnt_e;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .MODE(1), .CNT_W(8)) dut_up (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_enable(rx_enable),
        .tx_ready(tx_ready), .loop_en(loop_en), .clear_overrun(clear_overrun),
        .tx_data(tx_data_u), .tx_enable(tx_enable_u), .fifo_count(fifo_count_u),
        .overrun(overrun_u), .drop_cnt(drop_cnt_u)
    );

    uart_echo_buffer #(.DATA_W(8), .DEPTH(16), .MODE(0), .CNT_W(8)) dut_echo (
        .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_enable(rx_enable),
        .tx_ready(tx_ready), .loop_en(loop_en), .clear_overrun(clear_overrun),
        .tx_data(tx_data_e), .tx_enable(tx_enable_e), .fifo_count(fifo_count_e),
        .overrun(overrun_e), .drop_cnt(drop_cnt_e)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        resetn = 1'b0; rx_enable = 1'b0; rx_data = '0; tx_ready = 1'b0;
        loop_en = 1'b0; clear_overrun = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        tick();
    endtask

    // Push one word; current cycle is the rx_enable cycle
    task automatic push_word(input logic [7:0] d);
        rx_data = d; rx_enable = 1'b1;
        tick();
        rx_enable = 1'b0;
    endtask

    // Advance until the MODE=1 instance strobes tx_enable, bounded
    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (tx_enable_u === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++; if (tx_enable_u !== 1'b0) begin failures++; $display("FAIL reset_tx_enable got=%0h exp=0", tx_enable_u); end
        checks++; if (tx_data_u !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data_u); end
        checks++; if (fifo_count_u !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count_u); end
        checks++; if (overrun_u !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0h exp=0", overrun_u); end
        checks++; if (drop_cnt_u !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt_u); end
        reset_dut();
        checks++; if (tx_enable_u !== 1'b0 || fifo_count_u !== 5'd0) begin failures++; $display("FAIL post_reset_idle got=%0h/%0d exp=0/0", tx_enable_u, fifo_count_u); end
    endtask

    task automatic test_single();
        reset_dut();
        tx_ready = 1'b1; loop_en = 1'b1;
        push_word(8'h41);                              // now in cycle N+1
        checks++; if (fifo_count_u !== 5'd1) begin failures++; $display("FAIL single_count_n1 got=%0d exp=1", fifo_count_u); end
        checks++; if (tx_enable_u !== 1'b0) begin failures++; $display("FAIL single_early_tx got=%0h exp=0", tx_enable_u); end
        tick();                                        // cycle N+2
        checks++; if (tx_enable_u !== 1'b1) begin failures++; $display("FAIL single_tx_n2 got=%0h exp=1", tx_enable_u); end
        checks++; if (tx_data_u !== 8'h41) begin failures++; $display("FAIL single_data got=%0h exp=41", tx_data_u); end
        checks++; if (fifo_count_u !== 5'd0) begin failures++; $display("FAIL single_count_n2 got=%0d exp=0", fifo_count_u); end
        tx_ready = 1'b0;
        tick();
        checks++; if (tx_enable_u !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%0h exp=0", tx_enable_u); end
        tick();
        tx_ready = 1'b1;
    endtask

    task automatic test_fold();
        logic [7:0] in_v  [4] = '{8'h61, 8'h7A, 8'h5B, 8'h7B};
        logic [7:0] exp_v [4] = '{8'h41, 8'h5A, 8'h5B, 8'h7B};
        bit ok;
        reset_dut();
        loop_en = 1'b1; tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(in_v[i]);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_tx(ok);
            checks++; if (!ok) begin failures++; $display("FAIL fold_timeout got=none exp=tx_enable idx=%0d", i); end
            checks++; if (tx_data_u !== exp_v[i]) begin failures++; $display("FAIL fold_upper idx=%0d got=%0h exp=%0h", i, tx_data_u, exp_v[i]); end
            checks++; if (tx_data_e !== in_v[i]) begin failures++; $display("FAIL fold_plain idx=%0d got=%0h exp=%0h", i, tx_data_e, in_v[i]); end
            tx_ready = 1'b0; tick(); tick(); tx_ready = 1'b1;
        end
    endtask

    task automatic test_burst();
        bit ok;
        bit early_tx;
        reset_dut();
        loop_en = 1'b1; tx_ready = 1'b0; early_tx = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_word(8'(i));
            if (tx_enable_u !== 1'b0) early_tx = 1'b1;
        end
        tick();
        checks++; if (fifo_count_u !== 5'd16) begin failures++; $display("FAIL burst_count got=%0d exp=16", fifo_count_u); end
        checks++; if (early_tx) begin failures++; $display("FAIL burst_backpressure got=tx_enable exp=none"); end
        checks++; if (overrun_u !== 1'b0) begin failures++; $display("FAIL burst_overrun got=%0h exp=0", overrun_u); end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_tx(ok);
            checks++; if (!ok) begin failures++; $display("FAIL burst_timeout got=none exp=tx_enable idx=%0d", i); end
            checks++; if (tx_data_u !== 8'(i)) begin failures++; $display("FAIL burst_order idx=%0d got=%0h exp=%0h", i, tx_data_u, 8'(i)); end
            tick();                                    // tx_ready still high: no second pulse allowed
            checks++; if (tx_enable_u !== 1'b0) begin failures++; $display("FAIL burst_single_pulse idx=%0d got=%0h exp=0", i, tx_enable_u); end
            tx_ready = 1'b0; tick(); tick(); tx_ready = 1'b1;
        end
        checks++; if (fifo_count_u !== 5'd0) begin failures++; $display("FAIL burst_empty got=%0d exp=0", fifo_count_u); end
    endtask

    task automatic test_overrun();
        bit ok;
        reset_dut();
        loop_en = 1'b1; tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_word(8'h80 + 8'(i));
        for (int i = 0; i < 3; i++) push_word(8'hEE);
        checks++; if (overrun_u !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%0h exp=1", overrun_u); end
        checks++; if (drop_cnt_u !== 8'd3) begin failures++; $display("FAIL ovr_drop_cnt got=%0d exp=3", drop_cnt_u); end
        checks++; if (fifo_count_u !== 5'd16) begin failures++; $display("FAIL ovr_count got=%0d exp=16", fifo_count_u); end
        clear_overrun = 1'b1;
        push_word(8'hEE);
        clear_overrun = 1'b0;
        checks++; if (overrun_u !== 1'b1) begin failures++; $display("FAIL ovr_clear_race_flag got=%0h exp=1", overrun_u); end
        checks++; if (drop_cnt_u !== 8'd1) begin failures++; $display("FAIL ovr_clear_race_cnt got=%0d exp=1", drop_cnt_u); end
        clear_overrun = 1'b1; tick(); clear_overrun = 1'b0;
        checks++; if (overrun_u !== 1'b0 || drop_cnt_u !== 8'd0) begin failures++; $display("FAIL ovr_clear got=%0h/%0d exp=0/0", overrun_u, drop_cnt_u); end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_tx(ok);
            checks++; if (!ok || tx_data_u !== 8'h80 + 8'(i)) begin failures++; $display("FAIL ovr_contents idx=%0d got=%0h exp=%0h", i, tx_data_u, 8'h80 + 8'(i)); end
            tx_ready = 1'b0; tick(); tick(); tx_ready = 1'b1;
        end
        checks++; if (fifo_count_u !== 5'd0) begin failures++; $display("FAIL ovr_drained got=%0d exp=0", fifo_count_u); end
    endtask

    task automatic test_full_pop();
        bit ok;
        reset_dut();
        loop_en = 1'b1; tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_word(8'h20 + 8'(i));
        tx_ready = 1'b1; rx_data = 8'h55; rx_enable = 1'b1;   // pop and push on the same edge
        tick();
        rx_enable = 1'b0;
        checks++; if (fifo_count_u !== 5'd16) begin failures++; $display("FAIL fullpop_count got=%0d exp=16", fifo_count_u); end
        checks++; if (overrun_u !== 1'b0 || drop_cnt_u !== 8'd0) begin failures++; $display("FAIL fullpop_overrun got=%0h/%0d exp=0/0", overrun_u, drop_cnt_u); end
        checks++; if (tx_enable_u !== 1'b1 || tx_data_u !== 8'h20) begin failures++; $display("FAIL fullpop_first got=%0h/%0h exp=1/20", tx_enable_u, tx_data_u); end
        tx_ready = 1'b0; tick(); tick(); tx_ready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            logic [7:0] exp_d;
            exp_d = (i == 16) ? 8'h55 : 8'h20 + 8'(i);
            wait_tx(ok);
            checks++; if (!ok || tx_data_u !== exp_d) begin failures++; $display("FAIL fullpop_order idx=%0d got=%0h exp=%0h", i, tx_data_u, exp_d); end
            tx_ready = 1'b0; tick(); tick(); tx_ready = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit stray;
        reset_dut();
        loop_en = 1'b1; tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(8'h30 + 8'(i));
        tx_ready = 1'b1;
        wait_tx(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got=none exp=tx_enable"); end
        tx_ready = 1'b0;
        tick();                                        // DRAIN with 5 buffered
        checks++; if (fifo_count_u !== 5'd5) begin failures++; $display("FAIL rstmid_count_before got=%0d exp=5", fifo_count_u); end
        resetn = 1'b0;
        #1;
        checks++; if (fifo_count_u !== 5'd0 || tx_data_u !== 8'h00 || tx_enable_u !== 1'b0) begin
            failures++; $display("FAIL rstmid_async got=%0d/%0h/%0h exp=0/0/0", fifo_count_u, tx_data_u, tx_enable_u); end
        checks++; if (overrun_u !== 1'b0 || drop_cnt_u !== 8'd0) begin failures++; $display("FAIL rstmid_flags got=%0h/%0d exp=0/0", overrun_u, drop_cnt_u); end
        tick();
        resetn = 1'b1; tx_ready = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_enable_u !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray) begin failures++; $display("FAIL rstmid_no_tx got=tx_enable exp=none"); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fold();
        test_burst();
        test_overrun();
        test_full_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_echo_buffer
`default_nettype wire
